pcre_chain_engine: RTL and testbench



---
 rtl/pcre_chain_engine.sv | 121 ++++++++++++
 tb/tb_pcre_chain_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcre_chain_engine.sv
// Linear NFA for one PCRE rule: an ordered chain of character-class stages,
// any of which may be a Kleene-star stage. Consumes one decoded byte per en
// cycle and reports a sticky match, a first-match pulse and position, a
// saturating match count and a partial-match activity flag. sod clears all.
module pcre_chain_engine #(
    parameter int unsigned                   N_STAGES    = 23,
    parameter int unsigned                   N_CLASSES   = 128,
    parameter int unsigned                   CLS_W       = 7,
    parameter logic [N_STAGES*CLS_W-1:0]     STAGE_CLASS = '0,
    parameter logic [N_STAGES-1:0]           STAR_MASK   = '0,
    parameter bit                            ANCHORED    = 1'b0,
    parameter int unsigned                   POS_W       = 16,
    parameter int unsigned                   CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 sod,
    input  logic                 en,
    input  logic [N_CLASSES-1:0] cls_hit,
    output logic                 out,
    output logic                 match_pulse,
    output logic [POS_W-1:0]     match_pos,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 active
);

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Configuration sanity: the final stage is the accept state, so it must
    // consume a byte; a star there would make the rule match on nothing.
    if (N_STAGES < 1 || N_STAGES > 64) begin : g_bad_stage_count
        $error("pcre_chain_engine: N_STAGES must be in 1..64");
    end
    if (STAR_MASK[N_STAGES-1]) begin : g_bad_last_star
        $error("pcre_chain_engine: last stage must not be a star stage");
    end
    if (CLS_W != $clog2(N_CLASSES)) begin : g_bad_cls_w
        $error("pcre_chain_engine: CLS_W must equal clog2(N_CLASSES)");
    end

    logic [N_STAGES-1:0] stage_q;
    logic [N_STAGES-1:0] stage_d;
    logic [N_STAGES-1:0] stage_hit;
    logic                seen_q;      // at least one byte consumed since sod
    logic                en_d_q;      // previous edge consumed a byte
    logic [POS_W-1:0]    pos_q;
    logic [POS_W-1:0]    last_idx_q;
    logic                hit;

    // Classes not referenced by any stage are intentionally ignored.
    logic unused_cls;
    assign unused_cls = ^cls_hit;

    // Pick each stage's class bit out of the shared decoder bus.
    for (genvar i = 0; i < N_STAGES; i++) begin : g_sel
        assign stage_hit[i] = cls_hit[STAGE_CLASS[i*CLS_W +: CLS_W]];
    end

    // Next-state for the stage chain. carry walks the activity chain: it is
    // the predecessor's activity, and a star stage forwards it unchanged so
    // the following stage may fire with the star having matched zero bytes.
    always_comb begin
        logic carry;
        stage_d = '0;
        carry   = ANCHORED ? ~seen_q : 1'b1;
        for (int i = 0; i < N_STAGES; i++) begin
            stage_d[i] = stage_hit[i] & (carry | (STAR_MASK[i] & stage_q[i]));
            carry      = stage_q[i] | (STAR_MASK[i] & carry);
        end
    end

    assign hit    = stage_q[N_STAGES-1];
    assign active = |stage_q;

    // Byte-consumption state: stage registers, byte position, first-byte flag.
    always_ff @(posedge clk) begin
        if (sod) begin
            stage_q    <= '0;
            seen_q     <= 1'b0;
            en_d_q     <= 1'b0;
            pos_q      <= '0;
            last_idx_q <= '0;
        end else begin
            en_d_q <= en;
            if (en) begin
                stage_q    <= stage_d;
                seen_q     <= 1'b1;
                last_idx_q <= pos_q;
                if (pos_q != '1) begin
                    pos_q <= pos_q + POS_ONE;
                end
            end
        end
    end

    // Match reporting one edge behind hit; out is sticky until sod and the
    // first rise captures the index of the byte that completed the match.
    always_ff @(posedge clk) begin
        if (sod) begin
            out         <= 1'b0;
            match_pulse <= 1'b0;
            match_pos   <= '0;
            match_cnt   <= '0;
        end else begin
            match_pulse <= 1'b0;
            if (hit) begin
                out <= 1'b1;
                if (!out) begin
                    match_pulse <= 1'b1;
                    match_pos   <= last_idx_q;
                end
            end
            // Count once per consumed byte that leaves the accept stage set,
            // so idle cycles with hit still high do not recount.
            if (en_d_q && hit && match_cnt != '1) begin
                match_cnt <= match_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pcre_chain_engine.sv
// Bench for pcre_chain_engine with the rule a[^c]*d: an unanchored and an
// anchored instance share the same stimulus and are checked against a
// string-level reference model of the regular expression.
module tb_pcre_chain_engine;

    localparam int unsigned NS = 3;
    localparam int unsigned NC = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned PW = 8;
    localparam int unsigned KW = 2;
    // class 0 = 'a', class 2 = not 'c', class 3 = 'd'
    localparam logic [NS*CW-1:0] SCLS = {2'd3, 2'd2, 2'd0};
    localparam logic [NS-1:0]    SMSK = 3'b010;

    logic          clk = 1'b0;
    logic          sod = 1'b0;
    logic          en = 1'b0;
    logic [NC-1:0] cls_hit = '0;

    logic          out0, pulse0, act0, out1, pulse1, act1;
    logic [PW-1:0] pos0, pos1;
    logic [KW-1:0] cnt0, cnt1;

    int total = 0;
    int bad = 0;
    int pcnt0 = 0;
    int pcnt1 = 0;

    always #5 clk = ~clk;

    pcre_chain_engine #(
        .N_STAGES(NS), .N_CLASSES(NC), .CLS_W(CW), .STAGE_CLASS(SCLS),
        .STAR_MASK(SMSK), .ANCHORED(1'b0), .POS_W(PW), .CNT_W(KW)
    ) dut0 (
        .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .out(out0),
        .match_pulse(pulse0), .match_pos(pos0), .match_cnt(cnt0), .active(act0)
    );

    pcre_chain_engine #(
        .N_STAGES(NS), .N_CLASSES(NC), .CLS_W(CW), .STAGE_CLASS(SCLS),
        .STAR_MASK(SMSK), .ANCHORED(1'b1), .POS_W(PW), .CNT_W(KW)
    ) dut1 (
        .clk(clk), .sod(sod), .en(en), .cls_hit(cls_hit), .out(out1),
        .match_pulse(pulse1), .match_pos(pos1), .match_cnt(cnt1), .active(act1)
    );

    function automatic logic [NC-1:0] decode(input logic [7:0] c);
        decode = '0;
        decode[0] = (c == "a");
        decode[2] = (c != "c");
        decode[3] = (c == "d");
    endfunction

    // True when no 'c' appears in b[lo..hi] (empty range is true).
    function automatic bit no_c(input logic [7:0] b[$], input int lo, input int hi);
        no_c = 1'b1;
        for (int k = lo; k <= hi; k++) if (b[k] == "c") no_c = 1'b0;
    endfunction

    // A match of a[^c]*d ends at byte j.
    function automatic bit ends_at(input logic [7:0] b[$], input int j, input bit anch);
        ends_at = 1'b0;
        if (b[j] == "d") begin
            for (int s = 0; s < j; s++)
                if (b[s] == "a" && (!anch || s == 0) && no_c(b, s + 1, j - 1)) ends_at = 1'b1;
        end
    endfunction

    // Some prefix a[^c]* of the pattern ends at byte j (partial match alive).
    function automatic bit live_at(input logic [7:0] b[$], input int j, input bit anch);
        live_at = 1'b0;
        for (int s = 0; s <= j; s++)
            if (b[s] == "a" && (!anch || s == 0) && no_c(b, s + 1, j)) live_at = 1'b1;
    endfunction

    // Advance one clock and sample outputs 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse0) pcnt0++;
        if (pulse1) pcnt1++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_sod();
        sod = 1'b1;
        en = 1'b0;
        cls_hit = '0;
        tick();
        sod = 1'b0;
        pcnt0 = 0;
        pcnt1 = 0;
    endtask

    task automatic send_byte(input logic [7:0] c);
        en = 1'b1;
        cls_hit = decode(c);
        tick();
        en = 1'b0;
        cls_hit = '0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic test_reset();
        do_sod();
        total++;
        if ({out0, pulse0, pos0, cnt0, act0} !== '0) begin
            bad++;
            $display("FAIL reset0: got out=%b pulse=%b pos=%0d cnt=%0d act=%b, want all 0",
                     out0, pulse0, pos0, cnt0, act0);
        end
        total++;
        if ({out1, pulse1, pos1, cnt1, act1} !== '0) begin
            bad++;
            $display("FAIL reset1: got out=%b pulse=%b pos=%0d cnt=%0d act=%b, want all 0",
                     out1, pulse1, pos1, cnt1, act1);
        end
    endtask

    task automatic test_back_to_back();
        do_sod();
        send_byte("a");
        total++;
        if (act0 !== 1'b1 || out0 !== 1'b0) begin
            bad++;
            $display("FAIL ad_byte0: act=%b out=%b, want act=1 out=0", act0, out0);
        end
        send_byte("d");
        total++;
        if (out0 !== 1'b0 || pulse0 !== 1'b0) begin
            bad++;
            $display("FAIL ad_latency: out=%b pulse=%b right after last byte, want 0 0",
                     out0, pulse0);
        end
        tick();
        total++;
        if (out0 !== 1'b1 || pulse0 !== 1'b1 || pos0 !== 8'd1 || cnt0 !== 2'd1) begin
            bad++;
            $display("FAIL ad_match: out=%b pulse=%b pos=%0d cnt=%0d, want 1 1 1 1",
                     out0, pulse0, pos0, cnt0);
        end
        tick();
        total++;
        if (out0 !== 1'b1 || pulse0 !== 1'b0 || cnt0 !== 2'd1) begin
            bad++;
            $display("FAIL ad_pulse_end: out=%b pulse=%b cnt=%0d, want 1 0 1", out0, pulse0, cnt0);
        end
    endtask

    task automatic test_star();
        string s = "axxd";
        do_sod();
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            total++;
            if (act0 !== 1'b1) begin
                bad++;
                $display("FAIL axxd_active[%0d]: got %b want 1", i, act0);
            end
        end
        idle(2);
        total++;
        if (out0 !== 1'b1 || pos0 !== 8'd3 || cnt0 !== 2'd1 || pcnt0 != 1) begin
            bad++;
            $display("FAIL axxd_match: out=%b pos=%0d cnt=%0d pulses=%0d, want 1 3 1 1",
                     out0, pos0, cnt0, pcnt0);
        end
    endtask

    task automatic test_break();
        do_sod();
        send_str("ac");
        total++;
        if (act0 !== 1'b0) begin
            bad++;
            $display("FAIL acd_active: got %b want 0", act0);
        end
        send_byte("d");
        idle(2);
        total++;
        if (out0 !== 1'b0 || cnt0 !== 2'd0 || act0 !== 1'b0) begin
            bad++;
            $display("FAIL acd_nomatch: out=%b cnt=%0d act=%b, want 0 0 0", out0, cnt0, act0);
        end
    endtask

    task automatic test_gap();
        do_sod();
        send_byte("a");
        idle(3);
        send_byte("d");
        idle(2);
        total++;
        if (out0 !== 1'b1 || pos0 !== 8'd1 || cnt0 !== 2'd1) begin
            bad++;
            $display("FAIL gap_match: out=%b pos=%0d cnt=%0d, want 1 1 1", out0, pos0, cnt0);
        end
    endtask

    task automatic test_sod_mid();
        do_sod();
        send_byte("a");
        do_sod();
        total++;
        if ({out0, pulse0, pos0, cnt0, act0} !== '0) begin
            bad++;
            $display("FAIL sod_mid_clear: out=%b pulse=%b pos=%0d cnt=%0d act=%b, want all 0",
                     out0, pulse0, pos0, cnt0, act0);
        end
        send_byte("d");
        idle(2);
        total++;
        if (out0 !== 1'b0 || cnt0 !== 2'd0 || act0 !== 1'b0) begin
            bad++;
            $display("FAIL sod_mid_nomatch: out=%b cnt=%0d act=%b, want 0 0 0", out0, cnt0, act0);
        end
        // A byte presented together with sod must be discarded.
        sod = 1'b1;
        en = 1'b1;
        cls_hit = decode("a");
        tick();
        sod = 1'b0;
        en = 1'b0;
        send_byte("d");
        idle(2);
        total++;
        if (out0 !== 1'b0 || out1 !== 1'b0) begin
            bad++;
            $display("FAIL sod_priority: out0=%b out1=%b, want 0 0", out0, out1);
        end
    endtask

    task automatic test_anchor();
        do_sod();
        send_str("zad");
        idle(2);
        total++;
        if (out0 !== 1'b1 || pos0 !== 8'd2) begin
            bad++;
            $display("FAIL zad_unanchored: out=%b pos=%0d, want 1 2", out0, pos0);
        end
        total++;
        if (out1 !== 1'b0 || cnt1 !== 2'd0) begin
            bad++;
            $display("FAIL zad_anchored: out=%b cnt=%0d, want 0 0", out1, cnt1);
        end
        do_sod();
        send_str("ad");
        idle(2);
        total++;
        if (out1 !== 1'b1 || pos1 !== 8'd1) begin
            bad++;
            $display("FAIL ad_anchored: out=%b pos=%0d, want 1 1", out1, pos1);
        end
    endtask

    task automatic test_saturate();
        do_sod();
        send_str("adadadad");
        idle(2);
        total++;
        if (cnt0 !== 2'd3 || pos0 !== 8'd1 || out0 !== 1'b1 || pcnt0 != 1) begin
            bad++;
            $display("FAIL saturate: cnt=%0d pos=%0d out=%b pulses=%0d, want 3 1 1 1",
                     cnt0, pos0, out0, pcnt0);
        end
    endtask

    task automatic test_random();
        logic [7:0] alph[4] = '{"a", "c", "d", "x"};
        logic [7:0] b[$];
        for (int p = 0; p < 60; p++) begin
            int n;
            do_sod();
            b.delete();
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
                logic [7:0] c;
                bit ea0, ea1;
                c = alph[$urandom_range(0, 3)];
                b.push_back(c);
                send_byte(c);
                ea0 = live_at(b, j, 1'b0) || ends_at(b, j, 1'b0);
                ea1 = live_at(b, j, 1'b1) || ends_at(b, j, 1'b1);
                total++;
                if (act0 !== ea0 || act1 !== ea1) begin
                    bad++;
                    $display("FAIL rnd_active p%0d b%0d: got %b/%b want %b/%b",
                             p, j, act0, act1, ea0, ea1);
                end
                idle($urandom_range(0, 2));
            end
            idle(2);
            for (int a = 0; a < 2; a++) begin
                int cnt = 0;
                int fpos = 0;
                bit eo = 1'b0;
                logic go;
                logic [PW-1:0] gp;
                logic [KW-1:0] gc;
                int gpl;
                for (int j = 0; j < n; j++) begin
                    if (ends_at(b, j, a[0])) begin
                        if (!eo) fpos = j;
                        eo = 1'b1;
                        cnt++;
                    end
                end
                if (cnt > 3) cnt = 3;
                go  = (a == 0) ? out0 : out1;
                gp  = (a == 0) ? pos0 : pos1;
                gc  = (a == 0) ? cnt0 : cnt1;
                gpl = (a == 0) ? pcnt0 : pcnt1;
                total++;
                if (go !== eo || gp !== PW'(fpos) || gc !== KW'(cnt) || gpl != int'(eo)) begin
                    bad++;
                    $display("FAIL rnd_result p%0d anch=%0d: out=%b pos=%0d cnt=%0d pulses=%0d, want %b %0d %0d %0d",
                             p, a, go, gp, gc, gpl, eo, fpos, cnt, int'(eo));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_star();
        test_break();
        test_gap();
        test_sod_mid();
        test_anchor();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
